// File: rtl/ps2_pkg.sv
// ps2_pkg: shared definitions for the PS/2 key event receiver.
//   PS2_EXT / PS2_BRK : extended and break prefix scan codes
//   dec_state_e       : prefix decoder states
//   ps2_evt_t         : one key event {code, brk, ext}, 10 bits packed
package ps2_pkg;

  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_BRK = 8'hF0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXT,
    ST_BRK,
    ST_EXT_BRK
  } dec_state_e;

  typedef struct packed {
    logic [7:0] code;
    logic       brk;
    logic       ext;
  } ps2_evt_t;

endpackage

// File: rtl/ps2_evt_fifo.sv
// ps2_evt_fifo: synchronous FIFO for decoded key events.
//   clk, resetn : clock, synchronous active-low reset
//   push, din   : write request and data; ignored when full unless a pop
//                 happens in the same cycle
//   full        : no free entry
//   pop         : read request; ignored when empty
//   dout, empty : head entry (flop storage, stable until popped), empty flag
module ps2_evt_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  // Extra MSB on each pointer distinguishes full from empty.
  logic [AW:0]                  wr_q, rd_q;
  logic [DEPTH-1:0][WIDTH-1:0]  mem_q;
  logic                         do_push, do_pop;

  assign empty   = (wr_q == rd_q);
  assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem_q[rd_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_q  <= '0;
      rd_q  <= '0;
      mem_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q[AW-1:0]] <= din;
        wr_q                <= wr_q + PTR_ONE;
      end
      if (do_pop) rd_q <= rd_q + PTR_ONE;
    end
  end

endmodule

// File: rtl/ps2_key_event_rx.sv
// ps2_key_event_rx: PS/2 keyboard receiver producing queued key events.
//   clk, resetn            : system clock, synchronous active-low reset
//   ps2_clk, ps2_data      : raw asynchronous PS/2 lines
//   ev_valid/ev_ready      : event FIFO head handshake
//   ev_code/ev_break/ev_ext: head event (prefixes stripped)
//   frame_err              : 1-cycle pulse on bad start/stop/parity or timeout
//   overflow               : sticky, an event was dropped on a full FIFO
//   release_count          : wrapping count of accepted break events
module ps2_key_event_rx
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH     = 8,
  parameter int SYNC_STAGES    = 3,
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int CNT_W          = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             ps2_clk,
  input  logic             ps2_data,
  output logic             ev_valid,
  input  logic             ev_ready,
  output logic [7:0]       ev_code,
  output logic             ev_break,
  output logic             ev_ext,
  output logic             frame_err,
  output logic             overflow,
  output logic [CNT_W-1:0] release_count
);

  localparam int          TW      = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  // ---------------- synchroniser + edge detect
  logic [SYNC_STAGES-1:0] clk_sync_q, dat_sync_q;
  logic                   clk_prev_q;
  logic                   clk_cur, dat_cur, fall;

  assign clk_cur = clk_sync_q[SYNC_STAGES-1];
  assign dat_cur = dat_sync_q[SYNC_STAGES-1];
  assign fall    = clk_prev_q & ~clk_cur;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      clk_sync_q <= '1;
      dat_sync_q <= '1;
      clk_prev_q <= 1'b1;
    end else begin
      clk_sync_q <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
      dat_sync_q <= {dat_sync_q[SYNC_STAGES-2:0], ps2_data};
      clk_prev_q <= clk_cur;
    end
  end

  // ---------------- frame shifter + timeout
  // shift_q holds slots 0..9; the stop bit (slot 10) is checked live.
  logic [9:0]    shift_q;
  logic [3:0]    cnt_q;
  logic [TW-1:0] timer_q;
  logic          byte_vld_q;
  logic [7:0]    byte_q;
  logic          frame_err_q;
  logic          frame_ok;

  assign frame_ok = ~shift_q[0] & dat_cur & (^shift_q[9:1]);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      shift_q     <= '0;
      cnt_q       <= '0;
      timer_q     <= '0;
      byte_vld_q  <= 1'b0;
      byte_q      <= '0;
      frame_err_q <= 1'b0;
    end else begin
      byte_vld_q  <= 1'b0;
      frame_err_q <= 1'b0;
      if (fall) begin
        timer_q <= '0;
        if (cnt_q == 4'd10) begin
          cnt_q <= '0;
          if (frame_ok) begin
            byte_vld_q <= 1'b1;
            byte_q     <= shift_q[8:1];
          end else begin
            frame_err_q <= 1'b1;
          end
        end else begin
          shift_q[cnt_q] <= dat_cur;
          cnt_q          <= cnt_q + 4'd1;
        end
      end else if (cnt_q != 4'd0) begin
        if (timer_q == TO_LAST) begin
          timer_q     <= '0;
          cnt_q       <= '0;
          frame_err_q <= 1'b1;
        end else begin
          timer_q <= timer_q + 1'b1;
        end
      end else begin
        timer_q <= '0;
      end
    end
  end

  // ---------------- prefix decoder
  dec_state_e       state_q;
  ps2_evt_t         evt;
  logic             push, push_ok, pop_ok;
  logic             fifo_full, fifo_empty;
  logic             is_pfx;
  logic             overflow_q;
  logic [CNT_W-1:0] rel_cnt_q;
  ps2_evt_t         head;

  assign is_pfx = (byte_q == PS2_EXT) || (byte_q == PS2_BRK);

  always_comb begin
    evt.code = byte_q;
    evt.brk  = (state_q == ST_BRK) || (state_q == ST_EXT_BRK);
    evt.ext  = (state_q == ST_EXT) || (state_q == ST_EXT_BRK);
    push     = byte_vld_q & ~is_pfx;
  end

  // A full FIFO still accepts when the head leaves in the same cycle.
  assign pop_ok  = ev_ready & ~fifo_empty;
  assign push_ok = push & (~fifo_full | pop_ok);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= ST_IDLE;
      overflow_q <= 1'b0;
      rel_cnt_q  <= '0;
    end else begin
      if (frame_err_q) begin
        state_q <= ST_IDLE;
      end else if (byte_vld_q) begin
        unique case (state_q)
          ST_IDLE:    state_q <= (byte_q == PS2_EXT) ? ST_EXT :
                                 (byte_q == PS2_BRK) ? ST_BRK : ST_IDLE;
          ST_EXT:     state_q <= (byte_q == PS2_BRK) ? ST_EXT_BRK :
                                 (byte_q == PS2_EXT) ? ST_EXT : ST_IDLE;
          ST_BRK:     state_q <= is_pfx ? ST_BRK : ST_IDLE;
          ST_EXT_BRK: state_q <= is_pfx ? ST_EXT_BRK : ST_IDLE;
          default:    state_q <= ST_IDLE;
        endcase
      end
      if (push & ~push_ok) overflow_q <= 1'b1;
      if (push_ok & evt.brk) rel_cnt_q <= rel_cnt_q + 1'b1;
    end
  end

  ps2_evt_fifo #(
    .WIDTH ($bits(ps2_evt_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (push),
    .din    (evt),
    .full   (fifo_full),
    .pop    (ev_ready),
    .dout   (head),
    .empty  (fifo_empty)
  );

  assign ev_valid      = ~fifo_empty;
  assign ev_code       = head.code;
  assign ev_break      = head.brk;
  assign ev_ext        = head.ext;
  assign frame_err     = frame_err_q;
  assign overflow      = overflow_q;
  assign release_count = rel_cnt_q;

endmodule

// File: tb/tb_ps2_key_event_rx.sv
module tb_ps2_key_event_rx;

  localparam int H  = 8;    // clk cycles per PS/2 clock half period
  localparam int TO = 200;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       ev_valid, ev_ready;
  logic [7:0] ev_code;
  logic       ev_break, ev_ext, frame_err, overflow;
  logic [7:0] release_count;

  ps2_key_event_rx #(
    .FIFO_DEPTH(8), .SYNC_STAGES(3), .TIMEOUT_CYCLES(TO), .CNT_W(8)
  ) dut (
    .clk(clk), .resetn(resetn), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_code(ev_code),
    .ev_break(ev_break), .ev_ext(ev_ext), .frame_err(frame_err),
    .overflow(overflow), .release_count(release_count)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int ferr_cnt = 0;
  int vcyc = 0;
  logic [9:0] exp_q[$];
  logic       hold = 1'b0;
  logic [9:0] held;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: scoreboard pops on accepted events, head stability while stalled.
  always @(negedge clk) begin
    if (frame_err) ferr_cnt++;
    if (ev_valid) vcyc++;
    if (resetn && hold && ev_valid)
      check("head_stable", {22'd0, ev_code, ev_break, ev_ext}, {22'd0, held});
    if (resetn && ev_valid && ev_ready) begin
      if (exp_q.size() == 0) check("unexpected_event", {22'd0, ev_code, ev_break, ev_ext}, 32'hFFFF_FFFF);
      else check("event", {22'd0, ev_code, ev_break, ev_ext}, {22'd0, exp_q.pop_front()});
    end
    hold = resetn & ev_valid & ~ev_ready;
    held = {ev_code, ev_break, ev_ext};
  end

  task automatic ps2_bit(input logic b);
    ps2_data = b;
    repeat (H) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (H) @(negedge clk);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par);
    logic par;
    par = ~(^b) ^ bad_par;
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit(par);
    ps2_bit(1'b1);
    ps2_data = 1'b1;
    repeat (2 * H) @(negedge clk);
  endtask

  task automatic expect_ev(input logic [7:0] c, input logic brk, input logic ext);
    exp_q.push_back({c, brk, ext});
  endtask

  task automatic wait_drain(input string name);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 500) begin
      @(negedge clk);
      k++;
    end
    check(name, exp_q.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    ev_ready = 1'b1;
    repeat (3) @(negedge clk);
    // Reset state
    check("rst_valid", ev_valid, 0);
    check("rst_code", ev_code, 0);
    check("rst_flags", {ev_break, ev_ext, frame_err, overflow}, 0);
    check("rst_relcnt", release_count, 0);
    resetn = 1'b1;
    repeat (5) @(negedge clk);

    // 1: single make code, valid for exactly one cycle with ready held
    vcyc = 0;
    expect_ev(8'h1C, 1'b0, 1'b0);
    send_frame(8'h1C, 1'b0);
    wait_drain("t1_drain");
    check("t1_valid_cycles", vcyc, 1);

    // 2: extended release
    check("t2_relcnt_before", release_count, 0);
    vcyc = 0;
    send_frame(8'hE0, 1'b0);
    send_frame(8'hF0, 1'b0);
    check("t2_no_prefix_event", vcyc, 0);
    expect_ev(8'h75, 1'b1, 1'b1);
    send_frame(8'h75, 1'b0);
    wait_drain("t2_drain");
    check("t2_relcnt_after", release_count, 1);

    // 3: parity error, then a good frame
    ferr_cnt = 0;
    vcyc = 0;
    send_frame(8'h1C, 1'b1);
    check("t3_ferr_pulse", ferr_cnt, 1);
    check("t3_no_event", vcyc, 0);
    expect_ev(8'h32, 1'b0, 1'b0);
    send_frame(8'h32, 1'b0);
    wait_drain("t3_drain");

    // 4: overflow on the 9th event with ready low; drain in order
    ev_ready = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      if (i <= 8) expect_ev(8'(i), 1'b0, 1'b0);
      send_frame(8'(i), 1'b0);
    end
    check("t4_overflow", overflow, 1);
    check("t4_relcnt_unchanged", release_count, 1);
    ev_ready = 1'b1;
    wait_drain("t4_drain");
    check("t4_empty", ev_valid, 0);

    // 5: partial frame then timeout
    ferr_cnt = 0;
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b1);
    ps2_bit(1'b0);
    ps2_data = 1'b1;
    repeat (TO + 100) @(negedge clk);
    check("t5_ferr_pulse", ferr_cnt, 1);
    check("t5_cnt_zero", dut.cnt_q, 0);
    expect_ev(8'h2B, 1'b0, 1'b0);
    send_frame(8'h2B, 1'b0);
    wait_drain("t5_drain");

    // 6: reset mid-prefix discards the pending break
    send_frame(8'hE0, 1'b0);
    send_frame(8'hF0, 1'b0);
    resetn = 1'b0;
    @(negedge clk);
    check("t6_rst_valid", ev_valid, 0);
    check("t6_rst_flags", {ev_break, ev_ext, frame_err, overflow}, 0);
    check("t6_rst_relcnt", release_count, 0);
    resetn = 1'b1;
    repeat (3) @(negedge clk);
    expect_ev(8'h1C, 1'b0, 1'b0);
    send_frame(8'h1C, 1'b0);
    wait_drain("t6_drain");
    check("t6_relcnt", release_count, 0);

    check("final_queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
